// File: rtl/pe_mac_pkg.sv
// pe_pkg: shared mode encodings and saturation-bound helpers for the pe_mac
// processing element.
package pe_pkg;

    localparam logic PE_MODE_CHAIN = 1'b0;
    localparam logic PE_MODE_ACC   = 1'b1;

    // Largest representable partial sum for a given width and signedness.
    // Returned in a 64-bit container; callers slice the low psum_w bits.
    function automatic logic [63:0] psum_max(input int psum_w, input int is_signed);
        if (is_signed != 0) begin
            return (64'd1 << (psum_w - 1)) - 64'd1;
        end else if (psum_w >= 64) begin
            return '1;
        end else begin
            return (64'd1 << psum_w) - 64'd1;
        end
    endfunction

    // Smallest representable partial sum; two's complement minimum when signed.
    function automatic logic [63:0] psum_min(input int psum_w, input int is_signed);
        if (is_signed != 0) begin
            return ~((64'd1 << (psum_w - 1)) - 64'd1);
        end else begin
            return 64'd0;
        end
    endfunction

endpackage

// File: rtl/pe_mac_if.sv
// pe_mac_if: beat, weight-load and result signals of one systolic PE.
// The slave modport is the PE itself; the master modport is whatever feeds it.
interface pe_mac_if #(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int PSUM_W   = 24
);
    logic [DATA_W-1:0]   in_data;
    logic                in_data_vld;
    logic [WEIGHT_W-1:0] in_weight;
    logic                in_weight_load;
    logic [PSUM_W-1:0]   in_psum;
    logic                in_mode;
    logic                in_last;
    logic [PSUM_W-1:0]   out_psum;
    logic                out_psum_vld;
    logic                out_ovf;

    modport slave (
        input  in_data, in_data_vld, in_weight, in_weight_load,
        input  in_psum, in_mode, in_last,
        output out_psum, out_psum_vld, out_ovf
    );

    modport master (
        output in_data, in_data_vld, in_weight, in_weight_load,
        output in_psum, in_mode, in_last,
        input  out_psum, out_psum_vld, out_ovf
    );
endinterface

// File: rtl/pe_mult_pipe.sv
// pe_mult_pipe: behavioural DATA_W x WEIGHT_W multiplier followed by
// MULT_STAGES registers so synthesis can retime the product logic across
// them. A valid tag travels alongside the product.
module pe_mult_pipe #(
    parameter int DATA_W      = 8,
    parameter int WEIGHT_W    = 8,
    parameter int MULT_STAGES = 3,
    parameter int SIGNED      = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            in_a,
    input  logic [WEIGHT_W-1:0]          in_b,
    input  logic                         in_vld,
    output logic [DATA_W+WEIGHT_W-1:0]   out_prod,
    output logic                         out_vld
);
    localparam int   PW        = DATA_W + WEIGHT_W;
    localparam logic IS_SIGNED = (SIGNED != 0);

    logic [PW-1:0] a_x;
    logic [PW-1:0] b_x;
    logic [PW-1:0] prod_c;

    logic [PW-1:0]          prod_q [MULT_STAGES];
    logic [MULT_STAGES-1:0] vld_q;

    // Extend both operands to the full product width; the low PW bits of the
    // modular product are then the exact signed or unsigned result.
    always_comb begin
        a_x    = {{WEIGHT_W{IS_SIGNED & in_a[DATA_W-1]}}, in_a};
        b_x    = {{DATA_W{IS_SIGNED & in_b[WEIGHT_W-1]}}, in_b};
        prod_c = a_x * b_x;
    end

    // Shift product and valid tag through the pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MULT_STAGES; i++) begin
                prod_q[i] <= '0;
            end
            vld_q <= '0;
        end else begin
            prod_q[0] <= prod_c;
            vld_q[0]  <= in_vld;
            for (int i = 1; i < MULT_STAGES; i++) begin
                prod_q[i] <= prod_q[i-1];
                vld_q[i]  <= vld_q[i-1];
            end
        end
    end

    assign out_prod = prod_q[MULT_STAGES-1];
    assign out_vld  = vld_q[MULT_STAGES-1];

endmodule

// File: rtl/pe_mac.sv
// pe_mac: weight-stationary multiply-accumulate processing element.
// Chain mode adds the product to the upstream partial sum; accumulate mode
// keeps a local running sum and emits it on the last beat.
// Optional feature macro: PE_SATURATE_EN (clamp on overflow instead of wrap).
module pe_mac
    import pe_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int WEIGHT_W    = 8,
    parameter int PSUM_W      = 24,
    parameter int MULT_STAGES = 3,
    parameter int SIGNED      = 1
) (
    input  logic     clk,
    input  logic     rst,
    pe_mac_if.slave  bus
);
    localparam int   PW        = DATA_W + WEIGHT_W;
    localparam logic IS_SIGNED = (SIGNED != 0);

    if (PSUM_W < DATA_W + WEIGHT_W) begin : g_bad_psum_w
        $error("pe_mac: PSUM_W must be at least DATA_W + WEIGHT_W");
    end
    if (MULT_STAGES < 1) begin : g_bad_stages
        $error("pe_mac: MULT_STAGES must be at least 1");
    end

    logic [WEIGHT_W-1:0] weight_q;

    logic                in_vld_q;
    logic [DATA_W-1:0]   in_data_q;
    logic [WEIGHT_W-1:0] in_wgt_q;
    logic [PSUM_W-1:0]   in_psum_q;
    logic                in_mode_q;
    logic                in_last_q;

    logic [PSUM_W-1:0]      side_psum [MULT_STAGES];
    logic [MULT_STAGES-1:0] side_mode;
    logic [MULT_STAGES-1:0] side_last;

    logic [PW-1:0] fin_prod;
    logic          fin_vld;
    logic [PSUM_W-1:0] fin_psum;
    logic          fin_mode;
    logic          fin_last;

    logic [PSUM_W-1:0] acc_q;
    logic              acc_ovf_q;
    logic [PSUM_W-1:0] psum_q;
    logic              psum_vld_q;
    logic              ovf_q;

    logic [PSUM_W-1:0] op_a;
    logic [PSUM_W:0]   op_x;
    logic [PSUM_W:0]   prod_x;
    logic [PSUM_W:0]   sum_x;
    logic              add_ovf;
    logic [PSUM_W-1:0] sum_res;

    // Stationary weight; a beat in the load cycle still sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight_q <= '0;
        end else if (bus.in_weight_load) begin
            weight_q <= bus.in_weight;
        end
    end

    // Input stage captures the beat together with the weight it must use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_vld_q  <= 1'b0;
            in_data_q <= '0;
            in_wgt_q  <= '0;
            in_psum_q <= '0;
            in_mode_q <= PE_MODE_CHAIN;
            in_last_q <= 1'b0;
        end else begin
            in_vld_q  <= bus.in_data_vld;
            in_data_q <= bus.in_data;
            in_wgt_q  <= weight_q;
            in_psum_q <= bus.in_psum;
            in_mode_q <= bus.in_mode;
            in_last_q <= bus.in_last;
        end
    end

    pe_mult_pipe #(
        .DATA_W      (DATA_W),
        .WEIGHT_W    (WEIGHT_W),
        .MULT_STAGES (MULT_STAGES),
        .SIGNED      (SIGNED)
    ) u_mult (
        .clk      (clk),
        .rst      (rst),
        .in_a     (in_data_q),
        .in_b     (in_wgt_q),
        .in_vld   (in_vld_q),
        .out_prod (fin_prod),
        .out_vld  (fin_vld)
    );

    // Sideband pipeline keeps psum/mode/last aligned with the product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MULT_STAGES; i++) begin
                side_psum[i] <= '0;
            end
            side_mode <= '0;
            side_last <= '0;
        end else begin
            side_psum[0] <= in_psum_q;
            side_mode[0] <= in_mode_q;
            side_last[0] <= in_last_q;
            for (int i = 1; i < MULT_STAGES; i++) begin
                side_psum[i] <= side_psum[i-1];
                side_mode[i] <= side_mode[i-1];
                side_last[i] <= side_last[i-1];
            end
        end
    end

    assign fin_psum = side_psum[MULT_STAGES-1];
    assign fin_mode = side_mode[MULT_STAGES-1];
    assign fin_last = side_last[MULT_STAGES-1];

`ifdef PE_SATURATE_EN
    localparam logic [63:0]       MAX64    = psum_max(PSUM_W, SIGNED);
    localparam logic [63:0]       MIN64    = psum_min(PSUM_W, SIGNED);
    localparam logic [PSUM_W-1:0] PSUM_MAX = MAX64[PSUM_W-1:0];
    localparam logic [PSUM_W-1:0] PSUM_MIN = MIN64[PSUM_W-1:0];
`endif

    // One-bit-wider add exposes overflow; the carry-out bit of the widened
    // sum is the true sign, which picks the clamp direction when saturating.
    always_comb begin
        op_a    = (fin_mode == PE_MODE_CHAIN) ? fin_psum : acc_q;
        op_x    = {IS_SIGNED & op_a[PSUM_W-1], op_a};
        prod_x  = {{(PSUM_W + 1 - PW){IS_SIGNED & fin_prod[PW-1]}}, fin_prod};
        sum_x   = op_x + prod_x;
        add_ovf = IS_SIGNED ? (sum_x[PSUM_W] != sum_x[PSUM_W-1]) : sum_x[PSUM_W];
`ifdef PE_SATURATE_EN
        if (add_ovf) begin
            sum_res = (IS_SIGNED && sum_x[PSUM_W]) ? PSUM_MIN : PSUM_MAX;
        end else begin
            sum_res = sum_x[PSUM_W-1:0];
        end
`else
        sum_res = sum_x[PSUM_W-1:0];
`endif
    end

    // Final stage: emit chain results, or accumulate and flush on last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psum_q     <= '0;
            psum_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            acc_q      <= '0;
            acc_ovf_q  <= 1'b0;
        end else begin
            psum_vld_q <= 1'b0;
            if (fin_vld) begin
                if (fin_mode == PE_MODE_CHAIN) begin
                    psum_q     <= sum_res;
                    psum_vld_q <= 1'b1;
                    ovf_q      <= add_ovf;
                end else if (fin_last) begin
                    psum_q     <= sum_res;
                    psum_vld_q <= 1'b1;
                    ovf_q      <= acc_ovf_q | add_ovf;
                    acc_q      <= '0;
                    acc_ovf_q  <= 1'b0;
                end else begin
                    acc_q      <= sum_res;
                    acc_ovf_q  <= acc_ovf_q | add_ovf;
                end
            end
        end
    end

    assign bus.out_psum     = psum_q;
    assign bus.out_psum_vld = psum_vld_q;
    assign bus.out_ovf      = ovf_q;

endmodule

// File: tb/tb_pe_mac.sv
// tb_pe_mac: directed-vector bench for pe_mac. A default 24-bit PE covers
// chain, accumulate, weight collision, interleave, overflow and reset cases;
// a 16-bit PE covers accumulate-mode overflow (expectation depends on
// PE_SATURATE_EN).
module tb_pe_mac;
    logic clk;
    logic rst;

    pe_mac_if #(.DATA_W(8), .WEIGHT_W(8), .PSUM_W(24)) bus ();
    pe_mac_if #(.DATA_W(8), .WEIGHT_W(8), .PSUM_W(16)) bus16 ();

    pe_mac #(.DATA_W(8), .WEIGHT_W(8), .PSUM_W(24), .MULT_STAGES(3), .SIGNED(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pe_mac #(.DATA_W(8), .WEIGHT_W(8), .PSUM_W(16), .MULT_STAGES(3), .SIGNED(1)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    int total;
    int bad;

    logic [23:0] res_q [$];
    logic        ovf_q [$];
    logic [15:0] res16_q [$];
    logic        ovf16_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every result pulse, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.out_psum_vld) begin
            res_q.push_back(bus.out_psum);
            ovf_q.push_back(bus.out_ovf);
        end
        if (bus16.out_psum_vld) begin
            res16_q.push_back(bus16.out_psum);
            ovf16_q.push_back(bus16.out_ovf);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic [23:0] p, input logic m,
                                 input logic l, input logic wl, input logic [7:0] w);
        @(negedge clk);
        bus.in_data        = d;
        bus.in_data_vld    = 1'b1;
        bus.in_psum        = p;
        bus.in_mode        = m;
        bus.in_last        = l;
        bus.in_weight_load = wl;
        bus.in_weight      = w;
    endtask

    task automatic loadWeight(input logic [7:0] w);
        @(negedge clk);
        bus.in_data_vld    = 1'b0;
        bus.in_weight_load = 1'b1;
        bus.in_weight      = w;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_data_vld    = 1'b0;
            bus.in_weight_load = 1'b0;
            bus.in_last        = 1'b0;
        end
    endtask

    task automatic expectResult(input string tag, input logic [23:0] exp_psum, input logic exp_ovf);
        idle(1);
        for (int i = 0; i < 20 && res_q.size() == 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (res_q.size() == 0) begin
            checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            checkOutput({tag, "_psum"}, res_q.pop_front(), exp_psum);
            checkOutput({tag, "_ovf"}, ovf_q.pop_front(), exp_ovf);
        end
    endtask

    initial begin
        int lat;
        logic [23:0] lat_psum;
        logic        lat_ovf;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.in_data = '0;   bus.in_data_vld = 1'b0; bus.in_weight = '0;
        bus.in_weight_load = 1'b0; bus.in_psum = '0; bus.in_mode = 1'b0; bus.in_last = 1'b0;
        bus16.in_data = '0; bus16.in_data_vld = 1'b0; bus16.in_weight = '0;
        bus16.in_weight_load = 1'b0; bus16.in_psum = '0; bus16.in_mode = 1'b0; bus16.in_last = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_psum", bus.out_psum, 0);
        checkOutput("reset_vld", bus.out_psum_vld, 0);
        checkOutput("reset_ovf", bus.out_ovf, 0);
        rst = 1'b0;

        // Chain mode with latency measurement: 5 * -3 + 100 = 85.
        loadWeight(8'd5);
        applyStimulus(8'hFD, 24'd100, 1'b0, 1'b0, 1'b0, 8'd0);
        @(posedge clk);
        #1;
        bus.in_data_vld = 1'b0;
        lat = 0;
        lat_psum = '0;
        lat_ovf  = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_psum_vld) begin
                lat      = k;
                lat_psum = bus.out_psum;
                lat_ovf  = bus.out_ovf;
                break;
            end
        end
        checkOutput("chain_latency", lat, 4);
        checkOutput("chain_psum", lat_psum, 24'd85);
        checkOutput("chain_ovf", lat_ovf, 0);
        idle(3);
        res_q.delete();
        ovf_q.delete();

        // Accumulate: 2*(1+2+3) = 12, then a fresh single-beat group 2*4 = 8.
        loadWeight(8'd2);
        applyStimulus(8'd1, 24'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        applyStimulus(8'd2, 24'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        applyStimulus(8'd3, 24'd0, 1'b1, 1'b1, 1'b0, 8'd0);
        applyStimulus(8'd4, 24'd0, 1'b1, 1'b1, 1'b0, 8'd0);
        expectResult("acc_12", 24'd12, 1'b0);
        expectResult("acc_8", 24'd8, 1'b0);
        idle(6);
        checkOutput("acc_extra", res_q.size(), 0);

        // Weight-load collision: beat uses old weight 3, next beat uses 7.
        loadWeight(8'd3);
        applyStimulus(8'd10, 24'd0, 1'b0, 1'b0, 1'b1, 8'd7);
        applyStimulus(8'd10, 24'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        expectResult("coll_old", 24'd30, 1'b0);
        expectResult("coll_new", 24'd70, 1'b0);

        // Interleave: chain beat inside an accumulation leaves acc alone.
        loadWeight(8'd4);
        applyStimulus(8'd1, 24'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        applyStimulus(8'd1, 24'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        applyStimulus(8'd1, 24'd50, 1'b0, 1'b1, 1'b0, 8'd0);
        applyStimulus(8'd1, 24'd0, 1'b1, 1'b1, 1'b0, 8'd0);
        expectResult("ilv_chain", 24'd54, 1'b0);
        expectResult("ilv_acc", 24'd12, 1'b0);

        // Chain overflow at both signed 24-bit boundaries.
        loadWeight(8'd1);
        applyStimulus(8'd1, 24'h7FFFFF, 1'b0, 1'b0, 1'b0, 8'd0);
        applyStimulus(8'hFF, 24'h800000, 1'b0, 1'b0, 1'b0, 8'd0);
`ifdef PE_SATURATE_EN
        expectResult("ovf_pos", 24'h7FFFFF, 1'b1);
        expectResult("ovf_neg", 24'h800000, 1'b1);
`else
        expectResult("ovf_pos", 24'h800000, 1'b1);
        expectResult("ovf_neg", 24'h7FFFFF, 1'b1);
`endif

        // 16-bit PE: 3 * 127 * 127 = 48387 overflows on the last add.
        @(negedge clk);
        bus16.in_weight_load = 1'b1;
        bus16.in_weight      = 8'd127;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus16.in_weight_load = 1'b0;
            bus16.in_data_vld    = 1'b1;
            bus16.in_data        = 8'd127;
            bus16.in_psum        = '0;
            bus16.in_mode        = 1'b1;
            bus16.in_last        = (i == 2);
        end
        @(negedge clk);
        bus16.in_data_vld = 1'b0;
        bus16.in_last     = 1'b0;
        for (int i = 0; i < 20 && res16_q.size() == 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (res16_q.size() == 0) begin
            checkOutput("acc16_timeout", 64'd0, 64'd1);
        end else begin
`ifdef PE_SATURATE_EN
            checkOutput("acc16_psum", res16_q.pop_front(), 16'h7FFF);
`else
            checkOutput("acc16_psum", res16_q.pop_front(), 16'hBD03);
`endif
            checkOutput("acc16_ovf", ovf16_q.pop_front(), 1);
        end

        // Reset with two beats in flight; outputs drop to zero at once.
        idle(6);
        res_q.delete();
        ovf_q.delete();
        loadWeight(8'd9);
        applyStimulus(8'd1, 24'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        applyStimulus(8'd1, 24'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        @(posedge clk);
        #1;
        bus.in_data_vld = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("midrst_psum", bus.out_psum, 0);
        checkOutput("midrst_vld", bus.out_psum_vld, 0);
        checkOutput("midrst_ovf", bus.out_ovf, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(8);
        checkOutput("midrst_no_pulse", res_q.size(), 0);

        // Post-reset beat without reload sees weight 0.
        applyStimulus(8'd5, 24'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        expectResult("post_rst", 24'd0, 1'b0);

        idle(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
